// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, req/ack fetch to instruction memory, and a
// registered IF/ID slot backed by a one-entry skid buffer.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] newPC,
  output logic [31:0] Ins,
  output logic [31:0] nextPC,
  output logic        if_valid
);

  typedef enum logic [1:0] {REQ, FULL, DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] drop_addr;
  logic [31:0] skid_ins;
  logic [31:0] skid_npc;

  assign pc_inc = pc + 32'd4;

  // DROP keeps presenting the squashed address until memory completes it.
  always_comb begin
    imem_req  = !RST && (state != FULL);
    imem_addr = (state == DROP) ? drop_addr : pc;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= REQ;
      pc        <= RESET_PC;
      drop_addr <= '0;
      skid_ins  <= '0;
      skid_npc  <= '0;
      Ins       <= '0;
      nextPC    <= '0;
      if_valid  <= 1'b0;
    end else if (PCSrc) begin
      pc       <= newPC & ~32'd3;
      if_valid <= 1'b0;
      case (state)
        REQ: begin
          if (!imem_ack) begin
            drop_addr <= pc;
            state     <= DROP;
          end
        end
        FULL:    state <= REQ;
        default: state <= DROP;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (imem_ack) begin
            pc <= pc_inc;
            if (!if_valid || !stall) begin
              Ins      <= imem_rdata;
              nextPC   <= pc_inc;
              if_valid <= 1'b1;
            end else begin
              skid_ins <= imem_rdata;
              skid_npc <= pc_inc;
              state    <= FULL;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        FULL: begin
          if (!stall) begin
            Ins      <= skid_ins;
            nextPC   <= skid_npc;
            if_valid <= 1'b1;
            state    <= REQ;
          end
        end
        default: begin
          if (imem_ack) state <= REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomised scoreboard bench for if_stage: program-order model of delivered
// instructions, variable-latency memory, directed reset/stall/redirect cases.
module tb_if_stage;
  localparam logic [31:0] RPC  = 32'h0040_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imem_req, imem_ack, stall = 1'b0, PCSrc = 1'b0, if_valid;
  logic [31:0] imem_addr, imem_rdata, newPC = '0, Ins, nextPC;
  logic        imem_req2, imem_ack2, if_valid2;
  logic [31:0] imem_addr2, imem_rdata2, Ins2, nextPC2;

  int total = 0;
  int bad   = 0;
  int unsigned lat_min = 0, lat_max = 0, wait_cnt = 0, lat = 0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F96;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: acks after a random number of wait cycles, flushed by reset.
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_ack ? hash(imem_addr) : 32'hDEAD_BEEF;
  always @(posedge CLK) begin
    if (RST || !imem_req || imem_ack) begin
      wait_cnt <= 0;
      lat      <= $urandom_range(lat_max, lat_min);
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = imem_ack2 ? hash(imem_addr2) : 32'hDEAD_BEEF;

  if_stage dut (
    .CLK(CLK), .RST(RST), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .PCSrc(PCSrc),
    .newPC(newPC), .Ins(Ins), .nextPC(nextPC), .if_valid(if_valid)
  );

  if_stage #(.RESET_PC(RPC2)) dut2 (
    .CLK(CLK), .RST(RST), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .stall(1'b0), .PCSrc(1'b0),
    .newPC(32'h0), .Ins(Ins2), .nextPC(nextPC2), .if_valid(if_valid2)
  );

  // Scoreboard for the main DUT: expected program-order addresses.
  initial begin
    logic [31:0] q[$];
    logic [31:0] seq, a, t, p_ins, p_npc, hold_addr;
    logic        p_hold, p_redir, hold_v;
    int          idle;
    seq = RPC; p_ins = '0; p_npc = '0; hold_addr = '0;
    p_hold = 0; p_redir = 0; hold_v = 0; idle = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        q.delete();
        q.push_back(RPC);
        seq = RPC + 32'd4;
        p_hold = 0; p_redir = 0; hold_v = 0; idle = 0;
      end else begin
        if (p_hold) begin
          chk("hold_ins", Ins, p_ins);
          chk("hold_npc", nextPC, p_npc);
          chk("hold_valid", {31'b0, if_valid}, 32'd1);
        end
        if (p_redir) chk("redir_valid", {31'b0, if_valid}, 32'd0);
        if (hold_v && imem_req) chk("addr_stable", imem_addr, hold_addr);
        if (imem_req) chk("addr_align", imem_addr & 32'd3, 32'd0);
        if (if_valid && !stall) begin
          a = q.pop_front();
          chk("ins", Ins, hash(a));
          chk("nextpc", nextPC, a + 32'd4);
          if (q.size() == 0) begin
            q.push_back(seq);
            seq = seq + 32'd4;
          end
          idle = 0;
        end else begin
          idle++;
          if (idle > 100) begin
            total++; bad++;
            $display("FAIL watchdog: got no delivery for %0d cycles expected progress", idle);
            idle = 0;
          end
        end
        if (PCSrc) begin
          t = newPC & ~32'd3;
          q.delete();
          q.push_back(t);
          seq = t + 32'd4;
        end
        p_hold    = if_valid && stall && !PCSrc;
        p_ins     = Ins;
        p_npc     = nextPC;
        p_redir   = PCSrc;
        hold_v    = imem_req && !imem_ack;
        hold_addr = imem_addr;
      end
    end
  end

  // Wrap-around instance: never stalled, so every valid slot is consumed.
  initial begin
    logic [31:0] q2[$];
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        q2.delete();
        q2.push_back(RPC2);
      end else if (if_valid2) begin
        e = q2.pop_front();
        chk("wrap_ins", Ins2, hash(e));
        chk("wrap_nextpc", nextPC2, e + 32'd4);
        q2.push_back(e + 32'd4);
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_mid_req;
    bit found;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick;
      if (imem_req && !imem_ack && wait_cnt == 1) found = 1;
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL wait_req: got no pending request expected one within 50 cycles");
    end
  endtask

  task automatic check_after_reset(input string tag);
    chk({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
    chk({tag, "_ins"}, Ins, 32'd0);
    chk({tag, "_npc"}, nextPC, 32'd0);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, RPC);
  endtask

  initial begin
    logic [31:0] drop;
    bit seen;
    tick; tick;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_ins", Ins, 32'd0);
    chk("rst_npc", nextPC, 32'd0);
    chk("rst_req2", {31'b0, imem_req2}, 32'd0);
    RST = 1'b0;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RPC);
    chk("first_addr2", imem_addr2, RPC2);
    for (int i = 1; i <= 10; i++) begin
      tick;
      chk("stream_valid", {31'b0, if_valid}, 32'd1);
      chk("stream_addr", imem_addr, RPC + 32'(4 * i));
      chk("stream_addr2", imem_addr2, RPC2 + 32'(4 * i));
    end

    // Stall: one fetch lands in the skid buffer, then fetch pauses.
    stall = 1'b1;
    tick;
    chk("full_req", {31'b0, imem_req}, 32'd0);
    tick; tick;
    stall = 1'b0;
    repeat (4) tick;

    // Redirect during zero-wait fetch.
    PCSrc = 1'b1; newPC = 32'h0040_0103;
    tick;
    PCSrc = 1'b0;
    chk("redir_addr", imem_addr, 32'h0040_0100);
    repeat (4) tick;

    // Redirect with a slow request outstanding.
    lat_min = 3; lat_max = 3;
    wait_mid_req;
    PCSrc = 1'b1; newPC = 32'h0040_0200; drop = imem_addr;
    tick;
    PCSrc = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (imem_ack) seen = 1;
      else begin
        chk("drop_addr", imem_addr, drop);
        tick;
      end
    end
    tick;
    chk("drop_target", imem_addr, 32'h0040_0200);
    repeat (12) tick;

    // Reset while a dropped request is outstanding.
    wait_mid_req;
    PCSrc = 1'b1; newPC = 32'h0040_0300;
    tick;
    PCSrc = 1'b0; RST = 1'b1;
    #1;
    chk("drop_rst_req", {31'b0, imem_req}, 32'd0);
    tick;
    RST = 1'b0;
    #1;
    check_after_reset("drop_rst");

    // Reset while paused in FULL.
    lat_min = 0; lat_max = 0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick;
      if (if_valid) seen = 1;
    end
    stall = 1'b1;
    tick;
    chk("full2_req", {31'b0, imem_req}, 32'd0);
    tick;
    RST = 1'b1; stall = 1'b0;
    #1;
    chk("full_rst_req", {31'b0, imem_req}, 32'd0);
    tick;
    RST = 1'b0;
    #1;
    check_after_reset("full_rst");

    // Random traffic.
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      tick;
      stall = ($urandom_range(99, 0) < 30);
      PCSrc = ($urandom_range(99, 0) < 5);
      newPC = $urandom;
    end
    tick;
    stall = 1'b0; PCSrc = 1'b0;
    repeat (20) tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected completion before time limit");
    $fatal(1, "timeout");
  end

endmodule
